// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolution signals between the pipeline and the branch predictor.
interface branch_predictor_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned CNT_W       = 32
);
  localparam int unsigned IDX = $clog2(BTB_ENTRIES);

  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_next_pc;
  logic [IDX-1:0]   pred_index;

  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic [IDX-1:0]   upd_index;
  logic             upd_is_branch;
  logic             upd_is_jump;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic [XLEN-1:0]  upd_pred_next_pc;

  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_index, upd_is_branch, upd_is_jump,
           upd_taken, upd_target, upd_pred_next_pc,
    input  pred_taken, pred_next_pc, pred_index, mispredict, redirect_pc,
           br_count, mispred_count
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_index, upd_is_branch, upd_is_jump,
           upd_taken, upd_target, upd_pred_next_pc,
    output pred_taken, pred_next_pc, pred_index, mispredict, redirect_pc,
           br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters and optional gshare indexing.
// IF-stage lookup is combinational; EX-stage outcomes train the table on the clock edge.
module branch_predictor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned GHR_BITS    = 0,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned CNT_W       = 32
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);
  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;
  localparam int unsigned GW    = (GHR_BITS == 0) ? 1 : GHR_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [BTB_ENTRIES-1:0] jmp_q, jmp_d;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
  logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
  logic [XLEN-1:0]        tgt_d [BTB_ENTRIES];
  logic [CTR_BITS-1:0]    ctr_q [BTB_ENTRIES];
  logic [CTR_BITS-1:0]    ctr_d [BTB_ENTRIES];
  logic [GW-1:0]          ghr_q, ghr_d;
  logic [CNT_W-1:0]       br_count_q, br_count_d;
  logic [CNT_W-1:0]       mis_count_q, mis_count_d;

  logic [IDX-1:0]  ghr_ext_c;
  logic [IDX-1:0]  lk_idx_c;
  logic            lk_hit_c;
  logic            lk_taken_c;
  logic            upd_ctrl_c;
  logic            upd_tk_c;
  logic            upd_hit_c;
  logic            upd_mis_c;
  logic [XLEN-1:0] upd_actual_c;

  // History only contributes its low bits when gshare is enabled
  assign ghr_ext_c = (GHR_BITS == 0) ? '0 : IDX'(ghr_q);

  // Fetch lookup
  always_comb begin
    lk_idx_c   = bp.if_pc[IDX+1:2] ^ ghr_ext_c;
    lk_hit_c   = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == bp.if_pc[XLEN-1:IDX+2]);
    lk_taken_c = lk_hit_c && (jmp_q[lk_idx_c] || ctr_q[lk_idx_c][CTR_BITS-1]);
  end

  assign bp.pred_taken   = lk_taken_c;
  assign bp.pred_next_pc = lk_taken_c ? tgt_q[lk_idx_c] : bp.if_pc + XLEN'(4);
  assign bp.pred_index   = lk_idx_c;

  // Execute-stage resolution
  always_comb begin
    upd_ctrl_c   = bp.upd_is_branch || bp.upd_is_jump;
    upd_tk_c     = bp.upd_is_jump || (bp.upd_is_branch && bp.upd_taken);
    upd_actual_c = upd_tk_c ? bp.upd_target : bp.upd_pc + XLEN'(4);
    upd_mis_c    = bp.upd_valid && (upd_actual_c != bp.upd_pred_next_pc);
    upd_hit_c    = valid_q[bp.upd_index] &&
                   (tag_q[bp.upd_index] == bp.upd_pc[XLEN-1:IDX+2]);
  end

  assign bp.mispredict    = upd_mis_c;
  assign bp.redirect_pc   = upd_actual_c;
  assign bp.br_count      = br_count_q;
  assign bp.mispred_count = mis_count_q;

  // Table training, history and statistics
  always_comb begin
    valid_d     = valid_q;
    jmp_d       = jmp_q;
    tag_d       = tag_q;
    tgt_d       = tgt_q;
    ctr_d       = ctr_q;
    ghr_d       = ghr_q;
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;

    if (bp.upd_valid) begin
      if (upd_ctrl_c && upd_hit_c) begin
        if (upd_tk_c) begin
          if (ctr_q[bp.upd_index] != '1)
            ctr_d[bp.upd_index] = ctr_q[bp.upd_index] + CTR_BITS'(1);
          tgt_d[bp.upd_index] = bp.upd_target;
        end else if (ctr_q[bp.upd_index] != '0) begin
          ctr_d[bp.upd_index] = ctr_q[bp.upd_index] - CTR_BITS'(1);
        end
        jmp_d[bp.upd_index] = bp.upd_is_jump;
      end else if (upd_ctrl_c && upd_tk_c) begin
        valid_d[bp.upd_index] = 1'b1;
        tag_d[bp.upd_index]   = bp.upd_pc[XLEN-1:IDX+2];
        tgt_d[bp.upd_index]   = bp.upd_target;
        jmp_d[bp.upd_index]   = bp.upd_is_jump;
        ctr_d[bp.upd_index]   = CTR_WEAK;
      end else if (!upd_ctrl_c && upd_hit_c) begin
        valid_d[bp.upd_index] = 1'b0;
      end

      if ((GHR_BITS != 0) && bp.upd_is_branch)
        ghr_d = GW'({ghr_q, bp.upd_taken});
      if (upd_ctrl_c && (br_count_q != '1))
        br_count_d = br_count_q + CNT_W'(1);
      if (upd_mis_c && (mis_count_q != '1))
        mis_count_d = mis_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      jmp_q       <= '0;
      tag_q       <= '{default: '0};
      tgt_q       <= '{default: '0};
      ctr_q       <= '{default: '0};
      ghr_q       <= '0;
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      valid_q     <= valid_d;
      jmp_q       <= jmp_d;
      tag_q       <= tag_d;
      tgt_q       <= tgt_d;
      ctr_q       <= ctr_d;
      ghr_q       <= ghr_d;
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor: a bimodal and a gshare instance share stimulus
// and are compared every cycle against an entry-level table model, plus directed scenarios.
module tb_branch_predictor;
  logic clk;
  logic reset;

  branch_predictor_if #(.XLEN(32), .BTB_ENTRIES(16), .CNT_W(32)) bp0 ();
  branch_predictor_if #(.XLEN(32), .BTB_ENTRIES(16), .CNT_W(4))  bp1 ();

  branch_predictor #(.XLEN(32), .BTB_ENTRIES(16), .GHR_BITS(0), .CTR_BITS(2), .CNT_W(32))
    u_dut0 (.clk(clk), .reset(reset), .bp(bp0));
  branch_predictor #(.XLEN(32), .BTB_ENTRIES(16), .GHR_BITS(2), .CTR_BITS(3), .CNT_W(4))
    u_dut1 (.clk(clk), .reset(reset), .bp(bp1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one record per table entry, plain integer arithmetic
  bit              m_valid [2][16];
  int unsigned     m_tag   [2][16];
  logic [31:0]     m_tgt   [2][16];
  bit              m_jmp   [2][16];
  int              m_ctr   [2][16];
  int unsigned     m_ghr   [2];
  longint unsigned m_br    [2];
  longint unsigned m_mis   [2];

  function automatic int unsigned hist_mask(int d);  return (d == 0) ? 0 : 3;  endfunction
  function automatic int          ctr_max(int d);    return (d == 0) ? 3 : 7;  endfunction
  function automatic longint unsigned cnt_max(int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  function automatic int unsigned m_index(int d, logic [31:0] pc);
    return ((pc >> 2) % 16) ^ (m_ghr[d] & hist_mask(d));
  endfunction

  task automatic m_lookup(input int d, input logic [31:0] pc,
                          output int unsigned idx, output bit tk, output logic [31:0] npc);
    bit hit;
    idx = m_index(d, pc);
    hit = m_valid[d][idx] && (m_tag[d][idx] == (pc >> 6));
    tk  = hit && (m_jmp[d][idx] || (m_ctr[d][idx] > ctr_max(d) / 2));
    npc = tk ? m_tgt[d][idx] : pc + 32'd4;
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[d][i] = 0; m_tag[d][i] = 0; m_tgt[d][i] = 0; m_jmp[d][i] = 0; m_ctr[d][i] = 0;
      end
      m_ghr[d] = 0; m_br[d] = 0; m_mis[d] = 0;
    end
  endtask

  // Current stimulus
  logic        s_rst, s_uv, s_br, s_jmp, s_tk;
  logic [31:0] s_if_pc, s_pc, s_tgt, s_pnpc;
  int unsigned s_idx [2];

  function automatic logic [31:0] m_actual();
    return (s_jmp || (s_br && s_tk)) ? s_tgt : s_pc + 32'd4;
  endfunction

  task automatic m_update(input int d);
    int unsigned i;
    bit ctrl, tk, hit;
    if (!s_uv) return;
    i    = s_idx[d];
    ctrl = s_br || s_jmp;
    tk   = s_jmp || (s_br && s_tk);
    hit  = m_valid[d][i] && (m_tag[d][i] == (s_pc >> 6));
    if (ctrl && hit) begin
      m_ctr[d][i] = tk ? ((m_ctr[d][i] < ctr_max(d)) ? m_ctr[d][i] + 1 : m_ctr[d][i])
                       : ((m_ctr[d][i] > 0) ? m_ctr[d][i] - 1 : 0);
      if (tk) m_tgt[d][i] = s_tgt;
      m_jmp[d][i] = s_jmp;
    end else if (ctrl && tk) begin
      m_valid[d][i] = 1; m_tag[d][i] = s_pc >> 6; m_tgt[d][i] = s_tgt;
      m_jmp[d][i] = s_jmp; m_ctr[d][i] = (ctr_max(d) + 1) / 2;
    end else if (!ctrl && hit) begin
      m_valid[d][i] = 0;
    end
    if (s_br) m_ghr[d] = ((m_ghr[d] << 1) | 32'(s_tk)) & hist_mask(d);
    if (ctrl && m_br[d] < cnt_max(d)) m_br[d]++;
    if ((m_actual() != s_pnpc) && m_mis[d] < cnt_max(d)) m_mis[d]++;
  endtask

  task automatic drive();
    reset = s_rst;
    bp0.if_pc = s_if_pc;  bp1.if_pc = s_if_pc;
    bp0.upd_valid = s_uv; bp1.upd_valid = s_uv;
    bp0.upd_pc = s_pc;    bp1.upd_pc = s_pc;
    bp0.upd_index = 4'(s_idx[0]); bp1.upd_index = 4'(s_idx[1]);
    bp0.upd_is_branch = s_br; bp1.upd_is_branch = s_br;
    bp0.upd_is_jump = s_jmp;  bp1.upd_is_jump = s_jmp;
    bp0.upd_taken = s_tk;     bp1.upd_taken = s_tk;
    bp0.upd_target = s_tgt;   bp1.upd_target = s_tgt;
    bp0.upd_pred_next_pc = s_pnpc; bp1.upd_pred_next_pc = s_pnpc;
  endtask

  task automatic check_dut(input int d);
    logic pt, mp;
    logic [31:0] npc, rpc;
    logic [3:0] pi;
    logic [63:0] bc, mc;
    int unsigned ei;
    bit et;
    logic [31:0] en;
    if (d == 0) begin
      pt = bp0.pred_taken; npc = bp0.pred_next_pc; pi = bp0.pred_index;
      mp = bp0.mispredict; rpc = bp0.redirect_pc;
      bc = 64'(bp0.br_count); mc = 64'(bp0.mispred_count);
    end else begin
      pt = bp1.pred_taken; npc = bp1.pred_next_pc; pi = bp1.pred_index;
      mp = bp1.mispredict; rpc = bp1.redirect_pc;
      bc = 64'(bp1.br_count); mc = 64'(bp1.mispred_count);
    end
    m_lookup(d, s_if_pc, ei, et, en);
    check($sformatf("d%0d.pred_taken", d),    64'(pt),  64'(et));
    check($sformatf("d%0d.pred_next_pc", d),  64'(npc), 64'(en));
    check($sformatf("d%0d.pred_index", d),    64'(pi),  64'(ei));
    check($sformatf("d%0d.mispredict", d),    64'(mp),  64'(s_uv && (m_actual() != s_pnpc)));
    check($sformatf("d%0d.redirect_pc", d),   64'(rpc), 64'(m_actual()));
    check($sformatf("d%0d.br_count", d),      bc,       m_br[d]);
    check($sformatf("d%0d.mispred_count", d), mc,       m_mis[d]);
  endtask

  // One cycle: drive after the falling edge, compare, then advance the model past the rising edge
  task automatic step();
    @(negedge clk);
    drive();
    #1;
    if (s_rst) m_reset();
    check_dut(0);
    check_dut(1);
    if (!s_rst) begin
      m_update(0);
      m_update(1);
    end
  endtask

  task automatic set_idle(input logic [31:0] if_pc);
    s_if_pc = if_pc; s_uv = 0; s_pc = 0; s_br = 0; s_jmp = 0; s_tk = 0;
    s_tgt = 0; s_pnpc = 0; s_idx[0] = 0; s_idx[1] = 0;
  endtask

  task automatic set_upd(input logic [31:0] if_pc, input logic [31:0] pc, input logic br,
                         input logic jmp, input logic tk, input logic [31:0] tgt,
                         input logic [31:0] pnpc);
    s_if_pc = if_pc; s_uv = 1; s_pc = pc; s_br = br; s_jmp = jmp; s_tk = tk;
    s_tgt = tgt; s_pnpc = pnpc;
    s_idx[0] = m_index(0, pc);
    s_idx[1] = m_index(1, pc);
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    int unsigned r, ri;
    bit rt;
    logic [31:0] rn;

    m_reset();
    s_rst = 1; set_idle(32'h100); drive();
    repeat (2) @(negedge clk);
    s_rst = 0;

    // Reset state
    set_idle(32'h100); step();
    check("t1.pred_taken", 64'(bp0.pred_taken), 64'd0);
    check("t1.pred_next_pc", 64'(bp0.pred_next_pc), 64'h104);
    check("t1.br_count", 64'(bp0.br_count), 64'd0);

    // Taken branch allocates and mispredicts in the same cycle
    set_upd(32'h100, 32'h100, 1, 0, 1, 32'h80, 32'h104); step();
    check("t2.mispredict", 64'(bp0.mispredict), 64'd1);
    check("t2.redirect_pc", 64'(bp0.redirect_pc), 64'h80);
    set_idle(32'h100); step();
    check("t2.pred_taken", 64'(bp0.pred_taken), 64'd1);
    check("t2.pred_next_pc", 64'(bp0.pred_next_pc), 64'h80);
    check("t2.mispred_count", 64'(bp0.mispred_count), 64'd1);

    // Three not-taken outcomes walk the counter down and saturate at zero
    set_upd(32'h100, 32'h100, 1, 0, 0, 32'h80, 32'h80);  step();
    check("t3.mis0", 64'(bp0.mispredict), 64'd1);
    set_upd(32'h100, 32'h100, 1, 0, 0, 32'h80, 32'h104); step();
    check("t3.mis1", 64'(bp0.mispredict), 64'd0);
    set_upd(32'h100, 32'h100, 1, 0, 0, 32'h80, 32'h104); step();
    check("t3.mis2", 64'(bp0.mispredict), 64'd0);
    set_idle(32'h100); step();
    check("t3.pred_next_pc", 64'(bp0.pred_next_pc), 64'h104);
    check("t3.br_count", 64'(bp0.br_count), 64'd4);

    // Jump entries predict taken irrespective of the direction counter
    set_upd(32'h200, 32'h200, 0, 1, 0, 32'h400, 32'h204); step();
    set_idle(32'h200); step();
    check("t4.pred_taken", 64'(bp0.pred_taken), 64'd1);
    check("t4.pred_next_pc", 64'(bp0.pred_next_pc), 64'h400);
    set_upd(32'h200, 32'h200, 0, 1, 0, 32'h400, 32'h400); step();
    check("t4.mispredict", 64'(bp0.mispredict), 64'd0);

    // A non-control instruction hitting a stale entry invalidates it
    set_upd(32'h100, 32'h100, 1, 0, 1, 32'h80, 32'h80); step();
    set_upd(32'h100, 32'h100, 0, 0, 0, 32'h0, 32'h80);  step();
    check("t5.mispredict", 64'(bp0.mispredict), 64'd1);
    check("t5.redirect_pc", 64'(bp0.redirect_pc), 64'h104);
    set_idle(32'h100); step();
    check("t5.pred_taken", 64'(bp0.pred_taken), 64'd0);

    // Gshare index follows branch history
    s_rst = 1; set_idle(32'h10); step();
    s_rst = 0;
    set_upd(32'h10, 32'h10, 1, 0, 1, 32'h40, 32'h14); step();
    check("t6.idx_first", 64'(bp1.pred_index), 64'h4);
    set_upd(32'h10, 32'h10, 1, 0, 1, 32'h40, 32'h14); step();
    check("t6.idx_second", 64'(bp1.pred_index), 64'h5);
    set_idle(32'h18); step();
    check("t6.alias_taken", 64'(bp1.pred_taken), 64'd1);
    check("t6.alias_index", 64'(bp1.pred_index), 64'h5);

    // Reset raised while an update is pending discards it
    set_upd(32'h300, 32'h300, 1, 0, 1, 32'h500, 32'h304); step();
    s_rst = 1; reset = 1'b1; #1;
    m_reset();
    check("t7.br_count0", 64'(bp0.br_count), 64'd0);
    check("t7.br_count1", 64'(bp1.br_count), 64'd0);
    check("t7.pred_taken1", 64'(bp1.pred_taken), 64'd0);
    s_rst = 0;
    set_idle(32'h300); step();
    check("t7.no_alloc", 64'(bp0.pred_taken), 64'd0);
    set_idle(32'hFFFF_FFFC); step();
    check("t7.pc_wrap", 64'(bp0.pred_next_pc), 64'h0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: set_upd(rand_pc(), rand_pc(), 1, 0, 1'($urandom), 32'($urandom) & ~32'h3, 0);
        5, 6:          set_upd(rand_pc(), rand_pc(), 0, 1, 1'($urandom), 32'($urandom) & ~32'h3, 0);
        7, 8:          set_upd(rand_pc(), rand_pc(), 0, 0, 1'($urandom), 32'($urandom) & ~32'h3, 0);
        default:       set_idle(rand_pc());
      endcase
      if (s_uv) begin
        m_lookup(0, s_pc, ri, rt, rn);
        case ($urandom_range(0, 2))
          0:       s_pnpc = rn;
          1:       s_pnpc = s_pc + 32'd4;
          default: s_pnpc = s_tgt;
        endcase
        if ($urandom_range(0, 4) == 0) begin
          s_idx[0] = $urandom_range(0, 15);
          s_idx[1] = $urandom_range(0, 15);
        end
      end
      if ($urandom_range(0, 19) == 0) s_if_pc = 32'hFFFF_FFFC;
      s_rst = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline.
- Replaces the fixed PC+4 fetch path.
- IF stage looks up the fetch PC in a direct-mapped BTB with per-entry saturating counters and gets a predicted next PC.
- EX stage reports resolved control-flow outcomes; the block flags mispredicts, supplies the redirect PC, trains its tables and keeps statistics counters.
- Optional gshare indexing via a global history register.

Parameters:
XLEN, 32, datapath/PC width
BTB_ENTRIES, 16, number of table entries; power of two, >=2; IDX = log2(BTB_ENTRIES)
GHR_BITS, 0, global history length; 0 = bimodal (PC-only index), 1..IDX = gshare
CTR_BITS, 2, saturating counter width (>=1)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
if_pc  in  XLEN  fetch PC (IF stage)
pred_taken  out  1  lookup predicts redirect
pred_next_pc  out  XLEN  predicted next fetch PC
pred_index  out  IDX  table index used; carried down pipeline
upd_valid  in  1  EX-stage instruction valid (not bubble/flushed)
upd_pc  in  XLEN  PC of EX instruction
upd_index  in  IDX  pred_index captured at its fetch
upd_is_branch  in  1  conditional branch
upd_is_jump  in  1  JAL/JALR
upd_taken  in  1  resolved direction (ignored when upd_is_jump=1, treated as 1)
upd_target  in  XLEN  resolved target
upd_pred_next_pc  in  XLEN  pred_next_pc captured at its fetch
mispredict  out  1  EX instruction was mispredicted; flush IF/ID
redirect_pc  out  XLEN  correct next PC when mispredict=1
br_count  out  CNT_W  resolved control instructions
mispred_count  out  CNT_W  mispredicts

Behaviour:
Entry state: valid, tag = pc[XLEN-1:IDX+2], target[XLEN], is_jump, ctr[CTR_BITS].

Lookup (combinational on registered state):
- index = if_pc[IDX+1:2] XOR ({IDX-GHR_BITS zeros, ghr}); pred_index = index.
- hit = valid && tag match.
- pred_taken = hit && (is_jump || ctr MSB).
- pred_next_pc = pred_taken ? target : if_pc+4, modulo 2^XLEN (0xFFFFFFFC -> 0x0).

Resolution (combinational, only when upd_valid=1; else mispredict=0):
- actual = (upd_is_jump || (upd_is_branch && upd_taken)) ? upd_target : upd_pc+4.
- mispredict = (actual != upd_pred_next_pc); redirect_pc = actual always.

Training (rising clk edge, upd_valid=1), at entry upd_index:
- Control instruction, tag hit: ctr saturating +1 if taken else -1 (stays at 0 / all-ones); target <= upd_target if taken; is_jump <= upd_is_jump.
- Control instruction, miss, taken/jump: allocate. valid=1, tag, target, is_jump; ctr = 2^(CTR_BITS-1) (weakly taken). Overwrites any previous occupant.
- Control instruction, miss, not taken: no write.
- Non-control with tag hit (stale entry): valid <= 0.
- GHR (GHR_BITS>0): shift left and insert upd_taken on conditional branches only. Jumps and non-control leave it unchanged.
- br_count +1 per control instruction; mispred_count +1 per mispredict. Both saturate at all ones.

Ordering and boundary cases:
- Same-cycle lookup and update to one index: lookup sees pre-edge contents; the write is visible next cycle.
- Predictor state changes only through upd_*; no stall input.

Reset (asynchronous, immediate, mid-operation included; any update that cycle is discarded):
- All valid=0, ctr=0, GHR=0, counters=0.
- Hence pred_taken=0, pred_next_pc=if_pc+4; mispredict tracks upd_* inputs combinationally.

Test Plan:
1. After reset, if_pc=0x100 -> pred_taken=0, pred_next_pc=0x104, br_count=0.
2. Update: branch pc=0x100, taken, target=0x80, upd_pred_next_pc=0x104 -> mispredict=1, redirect_pc=0x80 same cycle. Next cycle, lookup 0x100 -> pred_taken=1, pred_next_pc=0x80; mispred_count=1.
3. Three not-taken updates at 0x100 (entry ctr=2) -> ctr 1,0,0. Lookup predicts 0x104. First not-taken update (upd_pred_next_pc=0x80) mispredicts; later ones do not. br_count=4.
4. JAL pc=0x200, target=0x400, allocated; force ctr to 0 via aliasing branch updates? No: issue lookup 0x200 -> pred_taken=1, 0x400 regardless of ctr. Then JAL update with upd_pred_next_pc=0x400 -> mispredict=0.
5. Non-control update pc=0x100 (entry valid), upd_pred_next_pc=0x80 -> mispredict=1, redirect_pc=0x104. Next cycle, lookup 0x100 -> not taken.
6. GHR_BITS=2: taken branch at 0x10 twice -> second update indexes 0x4^0b01. Then assert reset mid-update -> all outputs/counters at reset values, no allocation. Plus if_pc=0xFFFFFFFC -> pred_next_pc=0x0.
